// File: rtl/blk_mem_pkg.sv
// rtl/blk_mem_pkg.sv - shared FSM encoding and sizing for the blk_mem read streamer
package blk_mem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/blk_mem_skid_fifo.sv
// rtl/blk_mem_skid_fifo.sv - 2-entry skid FIFO absorbing in-flight blk_mem reads
module blk_mem_skid_fifo
  import blk_mem_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] slot [2];
  logic             wr_ptr;
  logic             rd_ptr;

  assign pop_data = slot[rd_ptr];
  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= push_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && empty));
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(count) <= SKID_DEPTH));

endmodule

// File: rtl/blk_mem_rd_streamer.sv
// rtl/blk_mem_rd_streamer.sv - sweeps len words from blk_mem and emits them as a ready/valid stream
module blk_mem_rd_streamer
  import blk_mem_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic [BIT_WIDTH-1:0]  mem_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BIT_WIDTH-1:0]  m_data,
  output logic                  m_last
);

  localparam logic [ADDR_WIDTH:0] LEN_ONE = 1;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   len_last;
  logic [ADDR_WIDTH:0]   issued_cnt;
  logic [ADDR_WIDTH:0]   beats_cnt;
  logic                  inflight;
  logic                  inflight_last;
  logic                  rd_en;
  logic                  issue_last;
  logic                  beat_last;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [1:0]            fifo_count;
  logic [1:0]            occupancy;
  logic [BIT_WIDTH:0]    fifo_head;

  assign len_last  = len_q - LEN_ONE;
  assign occupancy = fifo_count + {1'b0, inflight};
  assign fifo_pop  = m_valid & m_ready;

  // A pop frees a slot this cycle, so a read may be issued even when the skid is committed.
  assign rd_en      = (state == ST_ISSUE) && ((occupancy < 2'd2) || fifo_pop);
  assign issue_last = rd_en && (issued_cnt == len_last);
  assign beat_last  = fifo_pop && fifo_head[BIT_WIDTH];
  assign rd_addr    = base_q + issued_cnt[ADDR_WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (len == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (issue_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (beat_last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      issued_cnt    <= '0;
      beats_cnt     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && start) begin
        base_q     <= base_addr;
        len_q      <= len;
        issued_cnt <= '0;
        beats_cnt  <= '0;
      end else begin
        if (rd_en) issued_cnt <= issued_cnt + LEN_ONE;
        if (fifo_pop) beats_cnt <= beats_cnt + LEN_ONE;
      end
      // The read issued this cycle lands on mem_rd_data next cycle and is pushed then.
      inflight      <= rd_en;
      inflight_last <= issue_last;
    end
  end

  blk_mem_skid_fifo #(
    .WIDTH(BIT_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight),
    .push_data({inflight_last, mem_rd_data}),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign mem_rd_en    = rd_en;
  assign mem_addr_out = rd_en ? rd_addr : '0;
  assign m_valid      = ~fifo_empty;
  assign m_data       = m_valid ? fifo_head[BIT_WIDTH-1:0] : '0;
  assign m_last       = m_valid & fifo_head[BIT_WIDTH];

  a_occupancy: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(occupancy) <= SKID_DEPTH));
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_full && inflight && !fifo_pop));
  a_last_position: assert property (@(posedge clk) disable iff (!rst_n)
    (m_last -> (beats_cnt == len_last)));

endmodule

// File: tb/tb_blk_mem_rd_streamer.sv
// tb/tb_blk_mem_rd_streamer.sv - self-checking bench for blk_mem_rd_streamer with a behavioural blk_mem
module tb_blk_mem_rd_streamer;

  localparam int BW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, mem_rd_en, m_valid, m_last;
  logic [AW-1:0] mem_addr_out;
  logic [BW-1:0] mem_rd_data = '0;
  logic          m_ready = 1'b0;
  logic [BW-1:0] m_data;

  logic [BW-1:0] mem [DEPTH];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  blk_mem_rd_streamer #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr_out(mem_addr_out),
    .mem_rd_data(mem_rd_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr_out];

  bit   rec = 0;
  int   got_d[$];
  bit   got_l[$];
  int   got_c[$];
  int   addr_q[$];
  int   addr_c[$];
  int   done_c[$];
  int   busy_n, proto_err, max_occ, rd_total, beat_total;
  logic pv, pr, pl;
  logic [BW-1:0] pd;

  always @(negedge clk) begin
    if (rec) begin
      if (rd_total - beat_total > max_occ) max_occ = rd_total - beat_total;
      if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) proto_err++;
      if (m_last && !m_valid) proto_err++;
      if (m_valid && m_ready) begin
        got_d.push_back(int'(m_data)); got_l.push_back(m_last); got_c.push_back(cyc); beat_total++;
      end
      if (mem_rd_en) begin
        addr_q.push_back(int'(mem_addr_out)); addr_c.push_back(cyc); rd_total++;
      end
      if (done) done_c.push_back(cyc);
      if (busy) busy_n++;
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
    end else begin
      pv = 1'b0;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    got_d.delete(); got_l.delete(); got_c.delete();
    addr_q.delete(); addr_c.delete(); done_c.delete();
    busy_n = 0; proto_err = 0; max_occ = 0; rd_total = 0; beat_total = 0;
  endtask

  function automatic logic ready_pat(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k < 5) ? 1'b0 : (((k - 5) % 2) == 0);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic run_xfer(input int b, input int l, input int mode, input int repulse,
                          output int t0, output bit timed_out);
    clear_mon();
    @(posedge clk); #1;
    rec = 1; start = 1'b1; base_addr = AW'(b); len = (AW+1)'(l); m_ready = ready_pat(mode, 0);
    @(posedge clk); #1;
    start = 1'b0; base_addr = AW'($urandom); len = (AW+1)'($urandom);
    t0 = cyc;
    timed_out = 1'b1;
    for (int k = 0; k < 400; k++) begin
      m_ready = ready_pat(mode, k);
      if (repulse > 0 && k == repulse) begin
        start = 1'b1; base_addr = 4'd5; len = 5'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done_c.size() != 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rec = 0; m_ready = 1'b0;
  endtask

  // Expected stream: word i is mem[(base+i) mod depth], last flag only on word len-1.
  task automatic verify(input string tag, input int b, input int l, input int t0,
                        input bit to, input bit timing);
    int mism;
    int n;
    mism = 0;
    chk($sformatf("%s timeout", tag), to, 0);
    chk($sformatf("%s beats", tag), got_d.size(), l);
    chk($sformatf("%s reads", tag), addr_q.size(), l);
    n = (got_d.size() < l) ? got_d.size() : l;
    for (int i = 0; i < n; i++) begin
      if (got_d[i] != int'(mem[(b + i) % DEPTH])) mism++;
      if (got_l[i] != (i == l - 1)) mism++;
    end
    for (int i = 0; i < addr_q.size() && i < l; i++)
      if (addr_q[i] != (b + i) % DEPTH) mism++;
    chk($sformatf("%s data/last/addr mismatches", tag), mism, 0);
    chk($sformatf("%s done pulses", tag), done_c.size(), 1);
    chk($sformatf("%s stall/last protocol errors", tag), proto_err, 0);
    chk($sformatf("%s outstanding>2", tag), max_occ > 2, 0);
    if (done_c.size() > 0) begin
      chk($sformatf("%s busy cycles", tag), busy_n, done_c[0] - t0 + 1);
      if (got_c.size() > 0)
        chk($sformatf("%s done after last beat", tag), done_c[0], got_c[got_c.size()-1] + 1);
      if (l == 0)
        chk($sformatf("%s len0 done cycle", tag), done_c[0], t0);
    end
    if (timing && l > 0 && got_c.size() > 0 && addr_c.size() > 0) begin
      chk($sformatf("%s first addr cycle", tag), addr_c[0], t0);
      chk($sformatf("%s first beat cycle", tag), got_c[0], t0 + 2);
      chk($sformatf("%s last beat cycle", tag), got_c[got_c.size()-1], t0 + 1 + l);
    end
  endtask

  typedef struct {
    int base;
    int len;
    int mode;
    int repulse;
    int first;
    int lastd;
    bit timing;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int  t0;
    bit  to;
    int  b;
    int  l;
    for (int a = 0; a < DEPTH; a++) mem[a] = 16'(a * 3);
    vecs[0] = '{2, 4, 0, 0, 6, 15, 1'b1};
    vecs[1] = '{14, 4, 0, 0, 42, 3, 1'b1};
    vecs[2] = '{0, 8, 1, 0, 0, 21, 1'b0};
    vecs[3] = '{0, 0, 0, 0, 0, 0, 1'b1};
    vecs[4] = '{0, 16, 0, 6, 0, 45, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {busy, done, mem_rd_en, mem_addr_out, m_valid, m_data, m_last}, 0);
    #2 rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_xfer(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].repulse, t0, to);
      verify($sformatf("vec%0d", v), vecs[v].base, vecs[v].len, t0, to, vecs[v].timing);
      if (vecs[v].len > 0 && got_d.size() > 0) begin
        chk($sformatf("vec%0d first data", v), got_d[0], vecs[v].first);
        chk($sformatf("vec%0d last data", v), got_d[got_d.size()-1], vecs[v].lastd);
      end
    end

    // Async reset in the middle of a transfer drops the stream immediately.
    clear_mon();
    @(posedge clk); #1;
    rec = 1; start = 1'b1; base_addr = 4'd0; len = 5'd8; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 20 && beat_total < 3; k++) begin
      @(posedge clk); #1;
    end
    rec = 0;
    chk("rst beats before reset", beat_total, 3);
    chk("rst busy before reset", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst outputs immediate", {busy, done, mem_rd_en, mem_addr_out, m_valid, m_data, m_last}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    m_ready = 1'b0;
    run_xfer(1, 2, 0, 0, t0, to);
    verify("post-reset", 1, 2, t0, to, 1'b1);
    if (got_d.size() == 2) begin
      chk("post-reset beat0", got_d[0], 3);
      chk("post-reset beat1", got_d[1], 6);
    end

    for (int a = 0; a < DEPTH; a++) mem[a] = 16'($urandom);
    for (int r = 0; r < 20; r++) begin
      b = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, DEPTH);
      run_xfer(b, l, 2, 0, t0, to);
      verify($sformatf("rand%0d b=%0d l=%0d", r, b, l), b, l, t0, to, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
